// File: rtl/adder_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder_pipe_pkg                                                  |
// | Purpose  : Shared constants and helper functions for the pipelined         |
// |            adder/subtractor (chunk sizing, operating-mode encodings and     |
// |            parameter legality check).                                      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package adder_pipe_pkg;

  // Operating mode, carried on i_w_sub with every beat.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Width of the slice of the operands resolved by one pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal configurations: at least one stage, no more stages than bits,
  // and an operand width that splits evenly across the stages.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder_chunk                                                     |
// | Purpose  : Combinational ripple adder for one operand chunk. Produces the  |
// |            chunk sum, the carry-out towards the next chunk and the carry   |
// |            into the chunk's top bit (used for signed overflow when this    |
// |            chunk holds the operand sign bits).                             |
// | Ports    : a_i, b_i  - chunk operands (b_i already inverted for subtract)  |
// |            c_i       - carry-in from the chunk below                       |
// |            s_o       - chunk sum                                           |
// |            c_o       - carry-out of the chunk's top bit                    |
// |            ctop_o    - carry into the chunk's top bit                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adder_chunk #(
  parameter int p_cw = 4
) (
  input  logic [p_cw-1:0] a_i,
  input  logic [p_cw-1:0] b_i,
  input  logic            c_i,
  output logic [p_cw-1:0] s_o,
  output logic            c_o,
  output logic            ctop_o
);
  import adder_pipe_pkg::*;

  logic [p_cw:0] w_sum;

  // One extra bit captures the carry-out of the chunk.
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i} + {{p_cw{1'b0}}, c_i};
  assign s_o    = w_sum[p_cw-1:0];
  assign c_o    = w_sum[p_cw];

  // The sum bit is a ^ b ^ carry_in, so the carry into the top bit can be
  // recovered from the operands and the sum without tapping the chain.
  assign ctop_o = a_i[p_cw-1] ^ b_i[p_cw-1] ^ s_o[p_cw-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder_pipe                                                      |
// | Purpose  : Pipelined adder/subtractor with valid/ready handshake. The      |
// |            operands are split into p_stages chunks; stage k resolves chunk |
// |            k using the carry registered by stage k-1, so one result leaves |
// |            per cycle with only a chunk-wide carry chain between registers. |
// | Ports    : i_w_clk, i_w_rst_n       - clock, async active-low reset        |
// |            i_w_valid / o_w_ready    - operand beat handshake               |
// |            i_w_a, i_w_b, i_w_sub    - operands and mode (0 add, 1 sub)     |
// |            o_w_valid / i_w_ready    - result beat handshake                |
// |            o_w_s                    - sum/difference modulo 2^p_width      |
// |            o_w_carry                - unsigned carry-out (sub: no borrow)  |
// |            o_w_ovf                  - two's-complement signed overflow     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adder_pipe #(
  parameter int p_width  = 16,
  parameter int p_stages = 4
) (
  input  logic               i_w_clk,
  input  logic               i_w_rst_n,
  input  logic               i_w_valid,
  output logic               o_w_ready,
  input  logic [p_width-1:0] i_w_a,
  input  logic [p_width-1:0] i_w_b,
  input  logic               i_w_sub,
  output logic               o_w_valid,
  input  logic               i_w_ready,
  output logic [p_width-1:0] o_w_s,
  output logic               o_w_carry,
  output logic               o_w_ovf
);
  import adder_pipe_pkg::*;

  localparam int CW   = chunk_width(p_width, p_stages);
  localparam int LAST = p_stages - 1;

  if (!params_ok(p_width, p_stages)) begin : g_bad_params
    $error("adder_pipe: p_width must be a non-zero multiple of p_stages");
  end

  // Per-stage register outputs, gathered so stage k+1 can read stage k.
  // Lower chunks of the skew registers are not consumed downstream; they
  // are kept full width for uniform indexing and trimmed by synthesis.
  logic               v_st [p_stages];
  logic [p_width-1:0] a_st [p_stages];
  logic [p_width-1:0] b_st [p_stages];
  logic [p_width-1:0] s_st [p_stages];
  logic               c_st [p_stages];
  logic               ctop_st [p_stages];
  logic               ovf_w;

  // Whole pipeline advances as one; a full output stage that the consumer
  // is not taking freezes every stage (bubbles are not squeezed out).
  logic en;
  assign en        = !v_st[LAST] || i_w_ready;
  assign o_w_ready = en;

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    // Stage inputs
    logic               w_v;
    logic [p_width-1:0] w_a;
    logic [p_width-1:0] w_b;
    logic [p_width-1:0] w_s_in;
    logic               w_c;

    // Chunk adder results
    logic [CW-1:0]      w_sum;
    logic               w_cout;
    logic               w_ctop;

    // Stage registers
    logic               v_q;
    logic [p_width-1:0] a_q;
    logic [p_width-1:0] b_q;
    logic [p_width-1:0] s_q;
    logic [p_width-1:0] s_d;
    logic               c_q;

    if (k == 0) begin : g_first
      // Subtract as A + ~B + 1: invert B once here and feed the +1 as the
      // carry-in of chunk 0, so every later stage is a plain adder.
      assign w_v    = i_w_valid;
      assign w_a    = i_w_a;
      assign w_b    = i_w_sub ? ~i_w_b : i_w_b;
      assign w_c    = i_w_sub;
      assign w_s_in = '0;
    end else begin : g_next
      assign w_v    = v_st[k-1];
      assign w_a    = a_st[k-1];
      assign w_b    = b_st[k-1];
      assign w_c    = c_st[k-1];
      assign w_s_in = s_st[k-1];
    end

    adder_chunk #(
      .p_cw   (CW)
    ) u_chunk (
      .a_i    (w_a[k*CW +: CW]),
      .b_i    (w_b[k*CW +: CW]),
      .c_i    (w_c),
      .s_o    (w_sum),
      .c_o    (w_cout),
      .ctop_o (w_ctop)
    );

    // Lower result chunks pass through; this stage fills in chunk k.
    always_comb begin
      s_d                = w_s_in;
      s_d[k*CW +: CW]    = w_sum;
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= w_v;
        a_q <= w_a;
        b_q <= w_b;
        s_q <= s_d;
        c_q <= w_cout;
      end
    end

    assign v_st[k]    = v_q;
    assign a_st[k]    = a_q;
    assign b_st[k]    = b_q;
    assign s_st[k]    = s_q;
    assign c_st[k]    = c_q;
    assign ctop_st[k] = w_ctop;

    if (k == LAST) begin : g_last
      logic ovf_q;

      // Same sign on A and effective B but a different sign on the sum is
      // exactly the case where the carry into the sign bit differs from the
      // carry out of it, so the cheaper XOR form is used.
      always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ctop_st[k] ^ w_cout;
        end
      end

      assign ovf_w = ovf_q;
    end
  end

  assign o_w_valid = v_st[LAST];
  assign o_w_s     = s_st[LAST];
  assign o_w_carry = c_st[LAST];
  assign o_w_ovf   = ovf_w;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_adder_pipe                                                   |
// | Purpose  : Self-checking bench for adder_pipe: directed vector table,      |
// |            backpressured stream, mid-stream reset and exhaustive small     |
// |            configurations, all checked through per-DUT scoreboards.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_adder_pipe;
  import adder_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main DUT: 16 bits, 4 stages
  logic        m_valid, m_ready_o, m_sub, m_rdy, m_ovalid, m_c, m_o;
  logic [15:0] m_a, m_b, m_s;
  adder_pipe #(.p_width(16), .p_stages(4)) u_dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(m_valid), .o_w_ready(m_ready_o),
    .i_w_a(m_a), .i_w_b(m_b), .i_w_sub(m_sub), .o_w_valid(m_ovalid),
    .i_w_ready(m_rdy), .o_w_s(m_s), .o_w_carry(m_c), .o_w_ovf(m_o));

  // Small DUT x: 6 bits, 2 stages
  logic       x_valid, x_ready_o, x_sub, x_rdy, x_ovalid, x_c, x_o;
  logic [5:0] x_a, x_b, x_s;
  adder_pipe #(.p_width(6), .p_stages(2)) u_dut_x (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(x_valid), .o_w_ready(x_ready_o),
    .i_w_a(x_a), .i_w_b(x_b), .i_w_sub(x_sub), .o_w_valid(x_ovalid),
    .i_w_ready(x_rdy), .o_w_s(x_s), .o_w_carry(x_c), .o_w_ovf(x_o));

  // Small DUT y: 6 bits, 1 stage
  logic       y_valid, y_ready_o, y_sub, y_rdy, y_ovalid, y_c, y_o;
  logic [5:0] y_a, y_b, y_s;
  adder_pipe #(.p_width(6), .p_stages(1)) u_dut_y (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(y_valid), .o_w_ready(y_ready_o),
    .i_w_a(y_a), .i_w_b(y_b), .i_w_sub(y_sub), .o_w_valid(y_ovalid),
    .i_w_ready(y_rdy), .o_w_s(y_s), .o_w_carry(y_c), .o_w_ovf(y_o));

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  res_t q_m[$], q_x[$], q_y[$];
  res_t e_m, e_x, e_y;
  int   checks = 0;
  int   failures = 0;
  int   m_consumed = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference: whole-word arithmetic, independent of the chunking.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    logic [63:0] mask, aa, bb, full;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full = aa + bb + {63'd0, sub};
    r.s  = full[31:0] & mask[31:0];
    r.c  = full[w];
    r.o  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    return r;
  endfunction

  // Scoreboards: pop on consume first so a same-cycle accept/consume on an
  // empty queue does not match the beat that is only now being accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_m.delete();
    end else begin
      if (m_ovalid && m_rdy) begin
        chk("m_sb_nonempty", 64'(q_m.size() != 0), 64'd1);
        if (q_m.size() != 0) begin
          e_m = q_m.pop_front();
          chk("m_sb_result", 64'({m_s, m_c, m_o}), 64'({e_m.s[15:0], e_m.c, e_m.o}));
          m_consumed++;
        end
      end
      if (m_valid && m_ready_o) q_m.push_back(model(16, {16'd0, m_a}, {16'd0, m_b}, m_sub));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q_x.delete();
    end else begin
      if (x_ovalid && x_rdy) begin
        chk("x_sb_nonempty", 64'(q_x.size() != 0), 64'd1);
        if (q_x.size() != 0) begin
          e_x = q_x.pop_front();
          chk("x_sb_result", 64'({x_s, x_c, x_o}), 64'({e_x.s[5:0], e_x.c, e_x.o}));
        end
      end
      if (x_valid && x_ready_o) q_x.push_back(model(6, {26'd0, x_a}, {26'd0, x_b}, x_sub));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q_y.delete();
    end else begin
      if (y_ovalid && y_rdy) begin
        chk("y_sb_nonempty", 64'(q_y.size() != 0), 64'd1);
        if (q_y.size() != 0) begin
          e_y = q_y.pop_front();
          chk("y_sb_result", 64'({y_s, y_c, y_o}), 64'({e_y.s[5:0], e_y.c, e_y.o}));
        end
      end
      if (y_valid && y_ready_o) q_y.push_back(model(6, {26'd0, y_a}, {26'd0, y_b}, y_sub));
    end
  end

  // Present one beat on the main DUT and hold it until accepted.
  // Entered and left 1 time unit after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int   n;
    logic acc;
    n = 0;
    m_a = a; m_b = b; m_sub = sub; m_valid = 1'b1;
    do begin
      @(negedge clk); acc = m_ready_o;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    m_valid = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  // Single beat into an empty pipe: checks the 4-cycle latency and result.
  task automatic directed(input string name, input vec_t v);
    int lat;
    send(v.a, v.b, v.sub);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!m_ovalid && lat < 20);
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_result"}, 64'({m_s, m_c, m_o}), 64'({v.s, v.c, v.o}));
    @(posedge clk); #1;
  endtask

  vec_t        vecs[10];
  logic [18:0] snap;
  int          xn, yn;
  logic        xacc, yacc, x_abort, y_abort;

  initial begin
    vecs[0] = '{a:16'h00FF, b:16'h0001, sub:ADD, s:16'h0100, c:1'b0, o:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, sub:ADD, s:16'h0000, c:1'b1, o:1'b0};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, sub:ADD, s:16'h8000, c:1'b0, o:1'b1};
    vecs[3] = '{a:16'h0007, b:16'h0005, sub:SUB, s:16'h0002, c:1'b1, o:1'b0};
    vecs[4] = '{a:16'h0005, b:16'h0007, sub:SUB, s:16'hFFFE, c:1'b0, o:1'b0};
    vecs[5] = '{a:16'h8000, b:16'h0001, sub:SUB, s:16'h7FFF, c:1'b1, o:1'b1};
    vecs[6] = '{a:16'h0F0F, b:16'hF0F1, sub:ADD, s:16'h0000, c:1'b1, o:1'b0};
    vecs[7] = '{a:16'h0000, b:16'h0000, sub:SUB, s:16'h0000, c:1'b1, o:1'b0};
    vecs[8] = '{a:16'h8000, b:16'h8000, sub:ADD, s:16'h0000, c:1'b1, o:1'b1};
    vecs[9] = '{a:16'h1234, b:16'h1234, sub:SUB, s:16'h0000, c:1'b1, o:1'b0};

    rst_n = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0; m_rdy = 1'b1;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_sub = 1'b0; x_rdy = 1'b1;
    y_valid = 1'b0; y_a = '0; y_b = '0; y_sub = 1'b0; y_rdy = 1'b1;
    x_abort = 1'b0; y_abort = 1'b0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      m_a = 16'($urandom); m_b = 16'($urandom); m_sub = 1'($urandom);
      m_valid = 1'($urandom); m_rdy = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", 64'({m_ovalid, m_s, m_c, m_o}), 64'd0);
    end
    #2 rst_n = 1'b1; m_valid = 1'b0; m_rdy = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(m_ready_o), 64'd1);
    chk("idle_after_reset", 64'({m_ovalid, m_s, m_c, m_o}), 64'd0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) directed($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back stream with a 3-cycle consumer stall
    m_consumed = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'(i), 16'(15 - i), 1'(i % 2));
      end
      begin
        repeat (8) @(posedge clk);
        #1 m_rdy = 1'b0;
        @(negedge clk);
        snap = {m_ovalid, m_s, m_c, m_o};
        chk("stall_valid", 64'(m_ovalid), 64'd1);
        repeat (2) begin
          @(negedge clk);
          chk("stall_stable", 64'({m_ovalid, m_s, m_c, m_o}), 64'(snap));
          chk("stall_ready", 64'(m_ready_o), 64'd0);
        end
        @(posedge clk); #1 m_rdy = 1'b1;
      end
    join
    for (int n = 0; n < 20 && q_m.size() != 0; n++) @(posedge clk);
    #1;
    chk("stream_drained", 64'(q_m.size()), 64'd0);
    chk("stream_count", 64'(m_consumed), 64'd16);

    // Reset with three beats in flight
    m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i), 16'h0001, ADD);
    for (int n = 0; n < 20 && !m_ovalid; n++) @(negedge clk);
    chk("inflight_valid", 64'(m_ovalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(m_ovalid), 64'd0);
    chk("async_reset_data", 64'({m_s, m_c, m_o}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1; m_rdy = 1'b1;
    @(posedge clk); #1;
    directed("post_reset", '{a:16'h1234, b:16'h1111, sub:ADD, s:16'h2345, c:1'b0, o:1'b0});
    chk("post_reset_empty", 64'(q_m.size()), 64'd0);

    // Exhaustive small configurations with random consumer stalls
    fork
      begin
        for (int s = 0; s < 2 && !x_abort; s++)
          for (int a = 0; a < 64 && !x_abort; a++)
            for (int b = 0; b < 64 && !x_abort; b++) begin
              x_a = 6'(a); x_b = 6'(b); x_sub = 1'(s); x_valid = 1'b1; xn = 0;
              do begin
                @(negedge clk); xacc = x_ready_o;
                @(posedge clk); #1; x_rdy = ($urandom_range(3) != 0); xn++;
              end while (!xacc && xn < 50);
              if (!xacc) x_abort = 1'b1;
            end
        x_valid = 1'b0; x_rdy = 1'b1;
        chk("x_accept_all", 64'(x_abort), 64'd0);
        for (int n = 0; n < 20 && q_x.size() != 0; n++) @(posedge clk);
        #1 chk("x_drained", 64'(q_x.size()), 64'd0);
      end
      begin
        for (int s = 0; s < 2 && !y_abort; s++)
          for (int a = 0; a < 64 && !y_abort; a++)
            for (int b = 0; b < 64 && !y_abort; b++) begin
              y_a = 6'(a); y_b = 6'(b); y_sub = 1'(s); y_valid = 1'b1; yn = 0;
              do begin
                @(negedge clk); yacc = y_ready_o;
                @(posedge clk); #1; y_rdy = ($urandom_range(3) != 0); yn++;
              end while (!yacc && yn < 50);
              if (!yacc) y_abort = 1'b1;
            end
        y_valid = 1'b0; y_rdy = 1'b1;
        chk("y_accept_all", 64'(y_abort), 64'd0);
        for (int n = 0; n < 20 && q_y.size() != 0; n++) @(posedge clk);
        #1 chk("y_drained", 64'(q_y.size()), 64'd0);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
